// File: rtl/rr_stream_pkg.sv
// Shared types, FSM state encodings and the round-robin rotate helper
// for the registered stream arbiter.
package rr_stream_pkg;

  localparam int DEF_NUM_REQ = 4;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] idx_t;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_stream_arb_reg_rr.sv
// Round-robin pointer with lookahead search: grants the first requester after
// the last-served index, and can pin an offered-but-stalled grant.
module rr_stream_arb_reg_rr
  import rr_stream_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       en,
  input  logic                       hold,
  input  logic [NUM_REQ-1:0]         req,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic [NUM_REQ-1:0]         gnt_oh,
  output logic                       gnt_vld
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] ptr_q;
  logic          hold_q;
  logic [IW-1:0] hold_idx_q;
  logic [IW-1:0] srch_idx;
  logic          srch_vld;
  int unsigned   pos;

  // Search starts one past the last-served index, so a still-valid previous
  // winner is only picked when nobody else is requesting.
  always_comb begin
    srch_vld = 1'b0;
    srch_idx = '0;
    pos      = rr_next(32'(ptr_q), NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!srch_vld && req[pos]) begin
        srch_vld = 1'b1;
        srch_idx = IW'(pos);
      end
      pos = rr_next(pos, NUM_REQ);
    end
  end

  always_comb begin
    if (hold_q && req[hold_idx_q]) begin
      gnt_vld = 1'b1;
      gnt_idx = hold_idx_q;
    end else begin
      gnt_vld = srch_vld;
      gnt_idx = srch_idx;
    end
    gnt_oh = gnt_vld ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else if (clear) begin
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      if (en && gnt_vld)
        ptr_q <= gnt_idx;
      hold_q <= hold && gnt_vld;
      if (hold && gnt_vld)
        hold_idx_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/rr_stream_arb_reg.sv
// Merges NUM_REQ valid/ready streams onto one registered output with optional packet lock.
// state  | meaning: IDLE = arbitrate every beat; LOCKED = grant pinned to lock_idx until last
module rr_stream_arb_reg
  import rr_stream_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter bit PKT_MODE   = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            valid_i,
  output logic [NUM_REQ-1:0]            ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_REQ-1:0]            last_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          last_o,
  output logic [$clog2(NUM_REQ)-1:0]    idx_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic               load;
  logic               arb_en;
  logic               arb_hold;
  logic               accept;
  logic               gnt_vld;
  logic [IW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      lock_idx_q;
  logic [0:0]         state_q;

  assign load     = ~valid_o | ready_i;
  assign arb_en   = load & ~flush_i & (state_q == ST_IDLE);
  assign arb_hold = ~load & ~flush_i & (state_q == ST_IDLE);

  rr_stream_arb_reg_rr #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (flush_i),
    .en      (arb_en),
    .hold    (arb_hold),
    .req     (valid_i),
    .gnt_idx (gnt_idx),
    .gnt_oh  (gnt_oh),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    ready_o = '0;
    if (!flush_i && load) begin
      if (state_q == ST_LOCKED)
        ready_o[lock_idx_q] = 1'b1;
      else if (gnt_vld)
        ready_o = gnt_oh;
    end
  end

  assign sel_idx = (state_q == ST_LOCKED) ? lock_idx_q : gnt_idx;
  assign accept  = |(ready_o & valid_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
    end else if (accept) begin
      if (state_q == ST_IDLE) begin
        if (PKT_MODE && !last_i[sel_idx]) begin
          state_q    <= ST_LOCKED;
          lock_idx_q <= sel_idx;
        end
      end else if (last_i[sel_idx]) begin
        state_q <= ST_IDLE;
      end
    end
  end

  // Flush wins over a concurrent load; payload fields only move on an accepted beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      idx_o   <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (load) begin
      valid_o <= accept;
      if (accept) begin
        data_o <= data_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        last_o <= last_i[sel_idx];
        idx_o  <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_arb_reg.sv
// Scoreboard bench for rr_stream_arb_reg: a behavioural model predicts ready_o and
// accepted beats, which are queued and compared when the output handshakes.
module tb_rr_stream_arb_reg;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    valid_i;
  logic [N-1:0]    ready_o;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    last_i;
  logic            valid_o;
  logic            ready_i;
  logic [DW-1:0]   data_o;
  logic            last_o;
  logic [1:0]      idx_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]    idx;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t sb[$];
  int    obs[$];

  logic m_vo;
  int   m_ptr;
  logic m_lk;
  int   m_lock;
  logic m_hold;
  int   m_hidx;

  always #5 clk = ~clk;

  rr_stream_arb_reg #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .PKT_MODE   (1'b1)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .last_o  (last_o),
    .idx_o   (idx_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_vo = 1'b0; m_ptr = 0; m_lk = 1'b0; m_lock = 0; m_hold = 1'b0; m_hidx = 0;
    sb.delete();
  endtask

  // One clock cycle: called at a negedge with inputs set, returns at the next negedge.
  task automatic step();
    logic         load;
    logic [N-1:0] exp_rdy;
    logic         gv;
    logic         acc;
    int           g;
    int           k;
    beat_t        b;
    data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    #2;
    load = !m_vo || ready_i;
    gv = 1'b0;
    g  = 0;
    if (m_hold && valid_i[m_hidx]) begin
      gv = 1'b1;
      g  = m_hidx;
    end else begin
      for (int off = 1; off <= N; off++) begin
        if (!gv && valid_i[(m_ptr + off) % N]) begin
          gv = 1'b1;
          g  = (m_ptr + off) % N;
        end
      end
    end
    exp_rdy = '0;
    if (!flush) begin
      if (m_lk) begin
        if (load) exp_rdy[m_lock] = 1'b1;
      end else if (load && gv) begin
        exp_rdy[g] = 1'b1;
      end
    end
    total++;
    if (ready_o !== exp_rdy) begin
      bad++;
      $display("FAIL ready_o at %0t: got=%b exp=%b", $time, ready_o, exp_rdy);
    end
    total++;
    if (valid_o !== m_vo) begin
      bad++;
      $display("FAIL valid_o at %0t: got=%b exp=%b", $time, valid_o, m_vo);
    end
    if (m_vo && ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard at %0t: output beat with empty queue got idx=%0d", $time, idx_o);
      end else begin
        b = sb.pop_front();
        if ({idx_o, last_o, data_o} !== b) begin
          bad++;
          $display("FAIL out_beat at %0t: got idx=%0d last=%b data=%h exp idx=%0d last=%b data=%h",
                   $time, idx_o, last_o, data_o, b.idx, b.last, b.data);
        end
      end
      obs.push_back(int'(idx_o));
    end
    acc = |(exp_rdy & valid_i);
    k   = m_lk ? m_lock : g;
    if (flush) begin
      if (m_vo && !ready_i && sb.size() > 0) void'(sb.pop_front());
      m_vo = 1'b0; m_ptr = 0; m_lk = 1'b0; m_hold = 1'b0;
    end else begin
      if (load) begin
        m_vo = acc;
        if (acc) sb.push_back({2'(k), last_i[k], data_i[k*DW +: DW]});
      end
      if (!m_lk) begin
        if (acc) begin
          m_ptr = k;
          if (!last_i[k]) begin
            m_lk   = 1'b1;
            m_lock = k;
          end
        end
        m_hold = !load && gv;
        m_hidx = g;
      end else if (acc && last_i[k]) begin
        m_lk = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    valid_i = '0; ready_i = 1'b1; flush = 1'b0;
    step();
    step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: beats left in queue got=%0d exp=0", sb.size());
    end
  endtask

  task automatic do_flush();
    valid_i = '0; flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({valid_o, last_o, idx_o, data_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b last=%b idx=%0d data=%h exp all 0",
               valid_o, last_o, idx_o, data_o);
    end
    total++;
    if (ready_o !== '0) begin
      bad++;
      $display("FAIL reset_ready: got=%b exp=0000", ready_o);
    end
    rst = 1'b0;
    model_reset();
    step();
  endtask

  task automatic test_fairness();
    int exp_seq[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    obs.delete();
    valid_i = 4'b1111; last_i = 4'b1111; ready_i = 1'b1;
    repeat (9) step();
    drain();
    total++;
    if (obs.size() != 9) begin
      bad++;
      $display("FAIL fairness_count: got=%0d exp=9", obs.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        total++;
        if (obs[i] != exp_seq[i]) begin
          bad++;
          $display("FAIL fairness_idx[%0d]: got=%0d exp=%0d", i, obs[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    do_flush();
    obs.delete();
    valid_i = 4'b0110; last_i = 4'b0110; ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    held = data_o;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ready_o !== 4'b0000) begin
        bad++;
        $display("FAIL bp_ready[%0d]: got=%b exp=0000", i, ready_o);
      end
      step();
      total++;
      if (valid_o !== 1'b1 || idx_o !== 2'd1 || data_o !== held) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b idx=%0d data=%h exp valid=1 idx=1 data=%h",
                 i, valid_o, idx_o, data_o, held);
      end
    end
    ready_i = 1'b1;
    step();
    drain();
    total++;
    if (obs.size() != 2 || obs[0] != 1 || obs[1] != 2) begin
      bad++;
      $display("FAIL bp_seq: got n=%0d first=%0d second=%0d exp 1,2", obs.size(),
               (obs.size() > 0) ? obs[0] : -1, (obs.size() > 1) ? obs[1] : -1);
    end
  endtask

  task automatic test_pkt_lock();
    int exp_seq[4] = '{2, 2, 2, 0};
    do_flush();
    obs.delete();
    valid_i = 4'b0101; last_i = 4'b0001; ready_i = 1'b1;
    step();
    #1;
    total++;
    if (ready_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL pkt_ready0_beat2: got=%b exp=0", ready_o[0]);
    end
    step();
    valid_i = 4'b0001;
    #1;
    total++;
    if (ready_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL pkt_ready0_gap: got=%b exp=0", ready_o[0]);
    end
    step();
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL pkt_bubble: got valid=%b exp=0", valid_o);
    end
    valid_i = 4'b0101; last_i = 4'b0101;
    step();
    valid_i = 4'b0001; last_i = 4'b0001;
    step();
    drain();
    total++;
    if (obs.size() != 4) begin
      bad++;
      $display("FAIL pkt_count: got=%0d exp=4", obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs[i] != exp_seq[i]) begin
          bad++;
          $display("FAIL pkt_idx[%0d]: got=%0d exp=%0d", i, obs[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_starvation();
    int exp_seq[4] = '{3, 3, 1, 3};
    do_flush();
    obs.delete();
    valid_i = 4'b1000; last_i = 4'b1111; ready_i = 1'b1;
    step();
    step();
    valid_i = 4'b1010;
    step();
    step();
    drain();
    total++;
    if (obs.size() != 4) begin
      bad++;
      $display("FAIL starve_count: got=%0d exp=4", obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs[i] != exp_seq[i]) begin
          bad++;
          $display("FAIL starve_idx[%0d]: got=%0d exp=%0d", i, obs[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    do_flush();
    obs.delete();
    valid_i = 4'b0010; last_i = 4'b0000; ready_i = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_valid: got=%b exp=0", valid_o);
    end
    valid_i = 4'b1010; last_i = 4'b1111;
    step();
    step();
    drain();
    total++;
    if (obs.size() != 3 || obs[0] != 1 || obs[1] != 1 || obs[2] != 3) begin
      bad++;
      $display("FAIL flush_seq: got n=%0d idx=%0d,%0d,%0d exp 1,1,3", obs.size(),
               (obs.size() > 0) ? obs[0] : -1, (obs.size() > 1) ? obs[1] : -1,
               (obs.size() > 2) ? obs[2] : -1);
    end
  endtask

  task automatic test_async_reset();
    valid_i = 4'b1111; last_i = 4'b0000; ready_i = 1'b1;
    step();
    step();
    total++;
    if (valid_o !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre: got valid=%b exp=1", valid_o);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({valid_o, last_o, idx_o, data_o} !== '0) begin
      bad++;
      $display("FAIL areset_now: got valid=%b last=%b idx=%0d data=%h exp all 0",
               valid_o, last_o, idx_o, data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    valid_i = '0;
    model_reset();
    step();
    valid_i = 4'b1010; last_i = 4'b1111;
    step();
    drain();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; valid_i = '0; last_i = '0; data_i = '0; ready_i = 1'b1;
    model_reset();
    #1;
    rst = 1'b1;
    test_reset();
    test_fairness();
    test_backpressure();
    test_pkt_lock();
    test_starvation();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
